nn_result_reader: RTL and testbench

NN_RESULT_READER -- requirements
Module: nn_result_reader

---
 rtl/nn_pkg.sv | 19 +
 rtl/nn_result_reader.sv | 118 +++++++++++
 tb/tb_nn_result_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and default sizes for the NN result reader
// Purpose: FSM state encoding and default network geometry used by
//          nn_result_reader and anything that instantiates it.
// Ports:   none (package).
package nn_pkg;

  localparam int NN_LAYER_SIZE  = 4;
  localparam int NN_LAYER_DEPTH = 4;
  localparam int NN_BIT_SIZE    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } nn_state_t;

endpackage

// File: rtl/nn_result_reader.sv
// rtl/nn_result_reader.sv - reads one layer of NN outputs and streams it out
// Purpose: on start, issues one read per node of the selected layer, waits
//          READ_LATENCY cycles for the network data, and presents each word
//          on a valid/ready output until accepted.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start/start_layer one-cycle readout request and the layer to read
//   abort             cancel the current readout (no done pulse)
//   rd_en/rd_layer/rd_node/nn_y  read port towards the network
//   out_data/out_valid/out_ready/out_last  result word stream
//   busy/done         readout in progress / one-cycle completion pulse
module nn_result_reader
  import nn_pkg::*;
#(
  parameter int LAYER_SIZE   = NN_LAYER_SIZE,
  parameter int LAYER_DEPTH  = NN_LAYER_DEPTH,
  parameter int BIT_SIZE     = NN_BIT_SIZE,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(LAYER_DEPTH)-1:0] start_layer,
  input  logic                           abort,
  output logic                           rd_en,
  output logic [$clog2(LAYER_DEPTH)-1:0] rd_layer,
  output logic [$clog2(LAYER_SIZE)-1:0]  rd_node,
  input  logic [BIT_SIZE-1:0]            nn_y,
  output logic [BIT_SIZE-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int LW = $clog2(LAYER_DEPTH);
  localparam int NW = $clog2(LAYER_SIZE);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  nn_state_t         r_state;
  nn_state_t         w_next;
  logic [LW-1:0]     r_rd_layer;
  logic [NW-1:0]     r_rd_node;
  logic [CW-1:0]     r_cnt;
  logic [BIT_SIZE-1:0] r_out_data;
  logic              w_accept;
  logic              w_hs;
  logic              w_node_last;
  logic              w_cnt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = start && !abort;
    w_hs        = (r_state == ST_OUT) && out_ready;
    w_node_last = (r_rd_node == NW'(LAYER_SIZE - 1));
    w_cnt_zero  = (r_cnt == '0);
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_cnt_zero) w_next = ST_OUT;
      ST_OUT:   if (w_hs) w_next = w_node_last ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    // Abort beats everything, including a handshake in the same cycle.
    if (abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_layer <= '0;
      r_rd_node  <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rd_layer <= start_layer;
            r_rd_node  <= '0;
          end
        end
        ST_ISSUE: r_cnt <= CW'(READ_LATENCY - 1);
        ST_WAIT: begin
          // Counter spends READ_LATENCY cycles here, so the capture edge
          // lands exactly READ_LATENCY cycles after the rd_en cycle.
          if (!abort) begin
            if (w_cnt_zero) r_out_data <= nn_y;
            else            r_cnt      <= r_cnt - CW'(1);
          end
        end
        ST_OUT: begin
          if (w_hs && !w_node_last && !abort) r_rd_node <= r_rd_node + NW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = (r_state == ST_ISSUE);
  assign rd_layer  = r_rd_layer;
  assign rd_node   = r_rd_node;
  assign out_data  = r_out_data;
  assign out_valid = (r_state == ST_OUT);
  assign out_last  = (r_state == ST_OUT) && w_node_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_nn_result_reader.sv
// tb/tb_nn_result_reader.sv - directed self-checking bench for nn_result_reader
// Purpose: drives two instances (READ_LATENCY 1 and 3) from shared controls
//          against a latency-accurate network model returning 16*layer+node.
// Ports:   none (top-level bench).
module tb_nn_result_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  start_layer = 2'd0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;

  logic        rd_en_a, out_valid_a, out_last_a, busy_a, done_a;
  logic [1:0]  rd_layer_a, rd_node_a;
  logic [15:0] nn_y_a, out_data_a;
  logic        rd_en_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [1:0]  rd_layer_b, rd_node_b;
  logic [15:0] nn_y_b, out_data_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt_a = 0;
  int done_cnt_a = 0;
  int done_cyc_a = 0;
  int done_cnt_b = 0;
  int done_cyc_b = 0;
  logic [15:0] wq_a[$];
  logic        lq_a[$];
  logic [15:0] wq_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_result_reader #(.READ_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .start_layer(start_layer),
    .abort(abort), .rd_en(rd_en_a), .rd_layer(rd_layer_a), .rd_node(rd_node_a),
    .nn_y(nn_y_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_last(out_last_a), .busy(busy_a), .done(done_a)
  );

  nn_result_reader #(.READ_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .start_layer(start_layer),
    .abort(abort), .rd_en(rd_en_b), .rd_layer(rd_layer_b), .rd_node(rd_node_b),
    .nn_y(nn_y_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_last(out_last_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [15:0] word_of(input logic [1:0] layer, input logic [1:0] node);
    return {10'd0, layer, 2'b00, node};
  endfunction

  // Network model: data is valid only exactly READ_LATENCY cycles after the
  // read strobe; every other cycle returns a poison value.
  logic [15:0] pa;
  logic [15:0] pb [3];
  always @(posedge clk) begin
    pa    <= rd_en_a ? word_of(rd_layer_a, rd_node_a) : 16'hDEAD;
    pb[0] <= rd_en_b ? word_of(rd_layer_b, rd_node_b) : 16'hDEAD;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign nn_y_a = pa;
  assign nn_y_b = pb[2];

  // Monitor samples just before the rising edge, when inputs are settled.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (out_valid_a && out_ready) begin
        wq_a.push_back(out_data_a);
        lq_a.push_back(out_last_a);
      end
      if (out_valid_b && out_ready) wq_b.push_back(out_data_b);
      if (rd_en_a) rd_cnt_a++;
      if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
      if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] layer, output int t0);
    tick();
    start = 1'b1;
    start_layer = layer;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done_a(input int base);
    int n = 0;
    while (done_cnt_a == base && n < 200) begin tick(); n++; end
    if (done_cnt_a == base) check_eq("done_a_timeout", 0, 1);
  endtask

  task automatic wait_done_b(input int base);
    int n = 0;
    while (done_cnt_b == base && n < 200) begin tick(); n++; end
    if (done_cnt_b == base) check_eq("done_b_timeout", 0, 1);
  endtask

  task automatic check_words_a(input string tag, input logic [1:0] layer);
    check_eq({tag, "_count"}, wq_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_word"}, (wq_a.size() > i) ? 32'(wq_a[i]) : 32'hFFFF_FFFF,
               32'(word_of(layer, 2'(i))));
      check_eq({tag, "_last"}, (lq_a.size() > i) ? 32'(lq_a[i]) : 32'hFF, (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int t0;
    int base;
    int rc;
    int n;

    // Reset state
    tick(); tick();
    check_eq("reset_outputs",
             {rd_en_a, rd_layer_a, rd_node_a, out_data_a, out_valid_a, out_last_a, busy_a, done_a},
             0);
    rst_n = 1'b1;
    tick();

    // Basic readout, layer 2, both latencies
    wq_a.delete(); lq_a.delete(); wq_b.delete();
    base = done_cnt_a; rc = rd_cnt_a;
    pulse_start(2'd2, t0);
    check_eq("t1_rd_layer", rd_layer_a, 2);
    wait_done_a(base);
    check_eq("t1_start_to_done", done_cyc_a - t0, 12);
    tick();
    check_eq("t1_done_pulse", {done_a, busy_a}, 0);
    check_words_a("t1", 2'd2);
    check_eq("t1_rd_en_count", rd_cnt_a - rc, 4);
    wait_done_b(0);
    check_eq("t1_b_start_to_done", done_cyc_b - t0, 20);
    check_eq("t1_b_count", wq_b.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq("t1_b_word", (wq_b.size() > i) ? 32'(wq_b[i]) : 32'hFFFF_FFFF, 32 + i);
    repeat (3) tick();

    // Back-pressure on word 1
    wq_a.delete(); lq_a.delete();
    base = done_cnt_a;
    pulse_start(2'd3, t0);
    n = 0;
    while (!(rd_en_a && rd_node_a == 2'd1) && n < 50) begin tick(); n++; end
    out_ready = 1'b0;
    n = 0;
    while (!out_valid_a && n < 50) begin tick(); n++; end
    rc = rd_cnt_a;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_stall_valid", out_valid_a, 1);
      check_eq("t2_stall_data", out_data_a, 49);
    end
    check_eq("t2_no_extra_rd", rd_cnt_a - rc, 0);
    out_ready = 1'b1;
    wait_done_a(base);
    check_words_a("t2", 2'd3);
    repeat (25) tick();

    // Abort during WAIT of node 2, then restart on layer 1
    wq_a.delete(); lq_a.delete();
    base = done_cnt_a;
    pulse_start(2'd2, t0);
    n = 0;
    while (!(rd_en_a && rd_node_a == 2'd2) && n < 50) begin tick(); n++; end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t3_abort_idle", {busy_a, out_valid_a, rd_en_a}, 0);
    repeat (4) tick();
    check_eq("t3_no_done", done_cnt_a - base, 0);
    check_eq("t3_words_before_abort", wq_a.size(), 2);
    repeat (25) tick();
    wq_a.delete(); lq_a.delete();
    base = done_cnt_a;
    pulse_start(2'd1, t0);
    wait_done_a(base);
    check_words_a("t3_restart", 2'd1);
    repeat (25) tick();

    // Abort together with start in IDLE must not launch a readout
    rc = rd_cnt_a;
    tick();
    start = 1'b1; abort = 1'b1; start_layer = 2'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check_eq("t3_abort_start_idle", busy_a, 0);
    check_eq("t3_abort_start_no_rd", rd_cnt_a - rc, 0);
    repeat (25) tick();

    // Start pulsed during OUT is ignored
    wq_a.delete(); lq_a.delete();
    base = done_cnt_a; rc = rd_cnt_a;
    pulse_start(2'd0, t0);
    n = 0;
    while (!(out_valid_a && rd_node_a == 2'd1) && n < 50) begin tick(); n++; end
    start = 1'b1; start_layer = 2'd3;
    tick();
    start = 1'b0;
    check_eq("t4_layer_held", rd_layer_a, 0);
    wait_done_a(base);
    check_words_a("t4", 2'd0);
    check_eq("t4_rd_en_count", rd_cnt_a - rc, 4);
    tick();
    check_eq("t4_idle_after", busy_a, 0);
    repeat (25) tick();

    // Reset while holding a word in OUT
    wq_a.delete(); lq_a.delete();
    out_ready = 1'b0;
    pulse_start(2'd1, t0);
    n = 0;
    while (!out_valid_a && n < 50) begin tick(); n++; end
    check_eq("t5_in_out", out_valid_a, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_reset",
             {rd_en_a, rd_layer_a, rd_node_a, out_data_a, out_valid_a, out_last_a, busy_a, done_a},
             0);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    rc = rd_cnt_a;
    repeat (4) tick();
    check_eq("t5_idle_after_release", {busy_a, out_valid_a}, 0);
    check_eq("t5_no_rd_after_release", rd_cnt_a - rc, 0);
    check_eq("t5_no_words", wq_a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
